// File: rtl/wb_decoder_if.sv
// Pipelined Wishbone bus shared by the arbiter, the decoder and the followers.
interface wb_bus #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32
);
    localparam int SelWidth = DataWidth / 8;

    logic                 cycle;
    logic                 strobe;
    logic                 write_enable;
    logic [SelWidth-1:0]  select;
    logic [AddrWidth-1:0] addr;
    logic [DataWidth-1:0] write_data;
    logic [DataWidth-1:0] read_data;
    logic                 ack;
    logic                 error;
    logic                 stall;

    modport leader (
        output cycle, strobe, write_enable, select, addr, write_data,
        input  read_data, ack, error, stall
    );

    modport follower (
        input  cycle, strobe, write_enable, select, addr, write_data,
        output read_data, ack, error, stall
    );
endinterface

// File: rtl/wb_decoder.sv
// Address-window decoder and in-order response router for a pipelined Wishbone bus.
// Unmapped requests complete with an internally generated error one cycle after acceptance.
module wb_decoder #(
    parameter int DataWidth = 32,
    parameter int AddrWidth = 32,
    parameter int Count = 2,
    parameter logic [0:Count-1][AddrWidth-1:0] BaseAddrs = '{32'h0000_0000, 32'h1000_0000},
    parameter logic [0:Count-1][AddrWidth-1:0] AddrMasks = '{32'hFFFF_0000, 32'hF000_0000},
    parameter int MaxOutstanding = 4
) (
    input logic     clk,
    input logic     reset_n,
    wb_bus.follower leader,
    wb_bus.leader   followers [0:Count-1]
);
    localparam int IdxWidth = (Count > 1) ? $clog2(Count) : 1;
    localparam int CntWidth = $clog2(MaxOutstanding + 1);

    typedef struct packed {
        logic                unmapped;
        logic [IdxWidth-1:0] idx;
    } target_t;

    logic [CntWidth-1:0]  pending;
    target_t              cur_target;
    logic                 err_pending;

    target_t              dec_target;
    target_t              active;
    logic                 busy;
    logic                 dstall;
    logic                 accept;
    logic                 resp_ack;
    logic                 resp_err;
    logic [DataWidth-1:0] resp_data;

    logic [Count-1:0]     f_ack;
    logic [Count-1:0]     f_err;
    logic [Count-1:0]     f_stall;
    logic [DataWidth-1:0] f_rdata [Count];

    // Scanning from the top down lets the lowest matching window win.
    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        dec_target = '{unmapped: 1'b1, idx: '0};
        for (int i = Count - 1; i >= 0; i--) begin
            if ((leader.addr & AddrMasks[i]) == BaseAddrs[i]) begin
                dec_target = '{unmapped: 1'b0, idx: IdxWidth'(i)};
            end
        end
    end

    assign busy   = (pending != '0);
    assign active = busy ? cur_target : dec_target;
    assign dstall = (pending == CntWidth'(MaxOutstanding)) || (busy && (dec_target != cur_target));

    assign leader.stall = dstall | (!active.unmapped & f_stall[active.idx]);
    assign accept       = leader.cycle & leader.strobe & ~leader.stall;

    for (genvar g = 0; g < Count; g++) begin : g_port
        logic sel;
        assign sel = leader.cycle & ~active.unmapped & (active.idx == IdxWidth'(g));

        assign followers[g].cycle        = sel;
        assign followers[g].strobe       = sel & leader.strobe & ~dstall;
        assign followers[g].write_enable = leader.write_enable;
        assign followers[g].select       = leader.select;
        assign followers[g].addr         = leader.addr;
        assign followers[g].write_data   = leader.write_data;

        assign f_ack[g]   = followers[g].ack;
        assign f_err[g]   = followers[g].error;
        assign f_stall[g] = followers[g].stall;
        assign f_rdata[g] = followers[g].read_data;
    end

    // Responses are only honoured while something is outstanding, so late or
    // spurious follower replies never reach the leader.
    always_comb begin
        resp_ack  = 1'b0;
        resp_err  = 1'b0;
        resp_data = '0;
        if (cur_target.unmapped) begin
            resp_err = err_pending;
        end else if (busy) begin
            resp_ack  = f_ack[cur_target.idx];
            resp_err  = f_err[cur_target.idx];
            resp_data = f_rdata[cur_target.idx];
        end
    end

    assign leader.ack       = resp_ack;
    assign leader.error     = resp_err;
    assign leader.read_data = resp_data;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            pending     <= '0;
            cur_target  <= '{unmapped: 1'b0, idx: '0};
            err_pending <= 1'b0;
        end else if (!leader.cycle) begin
            pending     <= '0;
            err_pending <= 1'b0;
        end else begin
            pending     <= pending + CntWidth'(accept) - CntWidth'(resp_ack | resp_err);
            err_pending <= accept & dec_target.unmapped;
            if (accept) begin
                cur_target <= dec_target;
            end
        end
    end
endmodule

// File: tb/tb_wb_decoder.sv
// Self-checking bench for wb_decoder: decode table, directed corner sequences and
// a randomized run against a transaction-queue reference model.
module tb_wb_decoder;
    localparam int N = 2;
    localparam int MaxOut = 4;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    wb_bus #(.DataWidth(32), .AddrWidth(32)) lb ();
    wb_bus #(.DataWidth(32), .AddrWidth(32)) fb [0:N-1] ();

    wb_decoder #(
        .DataWidth(32),
        .AddrWidth(32),
        .Count(N),
        .MaxOutstanding(MaxOut)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .leader(lb),
        .followers(fb)
    );

    logic [N-1:0] f_cyc;
    logic [N-1:0] f_stb;
    logic [N-1:0] f_ack = '0;
    logic [N-1:0] f_err = '0;
    logic [N-1:0] f_stall = '0;
    logic [31:0]  f_rdata [N];

    for (genvar g = 0; g < N; g++) begin : g_fol
        assign f_cyc[g]        = fb[g].cycle;
        assign f_stb[g]        = fb[g].strobe;
        assign fb[g].ack       = f_ack[g];
        assign fb[g].error     = f_err[g];
        assign fb[g].stall     = f_stall[g];
        assign fb[g].read_data = f_rdata[g];
    end

    // Follower responder: each accepted strobe is answered 'lat' cycles later, in order.
    typedef struct { int due; logic [31:0] data; logic err; } resp_t;
    resp_t rq [N][$];
    int    lat [N];
    int    last_due [N];
    int    cyc = 0;
    int    err_pct = 0;
    bit    rec_en = 1'b0;
    bit    fixed_en = 1'b0;

    initial forever begin
        @(negedge clk);
        for (int p = 0; p < N; p++) begin
            if (rec_en && f_cyc[p] && f_stb[p] && !f_stall[p]) begin
                resp_t r;
                r.due = (cyc + lat[p] > last_due[p]) ? cyc + lat[p] : last_due[p] + 1;
                last_due[p] = r.due;
                r.data = fixed_en ? 32'hDEAD_BEEF : $urandom();
                r.err  = ($urandom_range(99) < err_pct);
                rq[p].push_back(r);
            end
        end
    end

    initial forever begin
        @(posedge clk);
        cyc++;
        for (int p = 0; p < N; p++) begin
            if ((f_ack[p] || f_err[p]) && rq[p].size() > 0) void'(rq[p].pop_front());
        end
        #1;
        for (int p = 0; p < N; p++) begin
            if (rq[p].size() > 0 && rq[p][0].due == cyc) begin
                f_ack[p]   = !rq[p][0].err;
                f_err[p]   = rq[p][0].err;
                f_rdata[p] = rq[p][0].data;
            end else begin
                f_ack[p]   = 1'b0;
                f_err[p]   = 1'b0;
                f_rdata[p] = '0;
            end
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic drive(input logic c, input logic s, input logic we, input logic [31:0] a);
        lb.cycle        = c;
        lb.strobe       = s;
        lb.write_enable = we;
        lb.addr         = a;
        lb.write_data   = a ^ 32'h5A5A_5A5A;
        lb.select       = 4'hF;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            step();
            drive(1'b0, 1'b0, 1'b0, 32'h0);
        end
    endtask

    task automatic flush_followers();
        for (int p = 0; p < N; p++) begin
            rq[p].delete();
            last_due[p] = 0;
        end
    endtask

    function automatic int decode(input logic [31:0] a);
        if ((a & 32'hFFFF_0000) == 32'h0000_0000) return 0;
        if ((a & 32'hF000_0000) == 32'h1000_0000) return 1;
        return N;
    endfunction

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  fstall;
        logic [1:0]  exp_stb;
        logic        exp_stall;
    } dec_vec_t;
    dec_vec_t vecs [12];

    typedef struct { int tgt; int acc; } txn_t;
    txn_t mq [$];

    int          acks;
    int          tgt;
    int          head;
    int          act;
    bit          busy;
    bit          can;
    logic        e_stall;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_data;
    logic [N-1:0] e_cyc;
    logic [N-1:0] e_stb;
    logic [31:0] a;
    int          sel;

    initial begin
        vecs = '{
            '{32'h0000_0010, 2'b00, 2'b01, 1'b0},
            '{32'h0000_FFFF, 2'b00, 2'b01, 1'b0},
            '{32'h0001_0000, 2'b00, 2'b00, 1'b0},
            '{32'h1000_0000, 2'b00, 2'b10, 1'b0},
            '{32'h1FFF_FFFC, 2'b00, 2'b10, 1'b0},
            '{32'h2000_0000, 2'b11, 2'b00, 1'b0},
            '{32'h0FFF_0000, 2'b00, 2'b00, 1'b0},
            '{32'h0000_0040, 2'b01, 2'b01, 1'b1},
            '{32'h0000_0040, 2'b10, 2'b01, 1'b0},
            '{32'h1000_0100, 2'b10, 2'b10, 1'b1},
            '{32'hF000_0000, 2'b00, 2'b00, 1'b0},
            '{32'h1234_5678, 2'b01, 2'b10, 1'b0}
        };
        for (int p = 0; p < N; p++) begin
            f_rdata[p] = '0;
            lat[p] = 2;
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset state
        step();
        step();
        sample();
        check("reset_ack", lb.ack, 0);
        check("reset_error", lb.error, 0);
        check("reset_rdata", lb.read_data, 0);
        check("reset_fcyc", f_cyc, 0);
        check("reset_pending", dut.pending, 0);
        step();
        reset_n = 1'b1;

        // Decode table: presented but withdrawn before the edge, so nothing is accepted
        foreach (vecs[i]) begin
            step();
            drive(1'b1, 1'b1, 1'b0, vecs[i].addr);
            f_stall = vecs[i].fstall;
            sample();
            check($sformatf("dec%0d_stb", i), f_stb, vecs[i].exp_stb);
            check($sformatf("dec%0d_cyc", i), f_cyc, vecs[i].exp_stb);
            check($sformatf("dec%0d_stall", i), lb.stall, vecs[i].exp_stall);
            drive(1'b0, 1'b0, 1'b0, 32'h0);
            f_stall = '0;
        end
        idle(2);
        rec_en = 1'b1;

        // Single read at 0x10, follower answers in cycle 2
        fixed_en = 1'b1;
        lat[0] = 2;
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h0000_0010);
        sample();
        check("rd_stb0", f_stb, 2'b01);
        check("rd_pend0", dut.pending, 0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h0000_0010);
        sample();
        check("rd_pend1", dut.pending, 1);
        check("rd_ack1", lb.ack, 0);
        step();
        sample();
        check("rd_ack2", lb.ack, 1);
        check("rd_data2", lb.read_data, 32'hDEAD_BEEF);
        step();
        sample();
        check("rd_pend3", dut.pending, 0);
        fixed_en = 1'b0;
        idle(2);

        // Four back-to-back writes to port 1, fifth stalled until the first ack
        lat[1] = 4;
        acks = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            drive(1'b1, 1'b1, 1'b1, 32'h1000_0000 + 32'(4 * k));
            sample();
            check($sformatf("b2b_stall%0d", k), lb.stall, 0);
            check($sformatf("b2b_stb%0d", k), f_stb, 2'b10);
            if (k == 0) begin
                check("b2b_waddr", fb[1].addr, 32'h1000_0000);
                check("b2b_wdata", fb[1].write_data, 32'h1000_0000 ^ 32'h5A5A_5A5A);
                check("b2b_we", fb[1].write_enable, 1);
            end
        end
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h1000_0010);
        sample();
        check("b2b_5th_stall", lb.stall, 1);
        check("b2b_5th_stb", f_stb, 2'b00);
        check("b2b_first_ack", lb.ack, 1);
        acks += int'(lb.ack);
        step();
        sample();
        check("b2b_5th_accept", lb.stall, 0);
        acks += int'(lb.ack);
        for (int k = 0; k < 8; k++) begin
            step();
            drive(1'b1, 1'b0, 1'b0, 32'h1000_0010);
            sample();
            acks += int'(lb.ack);
        end
        check("b2b_ack_count", acks, 5);
        check("b2b_pend_end", dut.pending, 0);
        idle(2);

        // Port 0 write then port 1 read: held off until port 0 acks
        lat[0] = 2;
        lat[1] = 2;
        step();
        drive(1'b1, 1'b1, 1'b1, 32'h0000_0020);
        sample();
        check("sw_stb0", f_stb, 2'b01);
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h1000_0004);
        sample();
        check("sw_stall1", lb.stall, 1);
        check("sw_stb1", f_stb, 2'b00);
        check("sw_cyc1", f_cyc, 2'b01);
        step();
        sample();
        check("sw_ack2", lb.ack, 1);
        check("sw_stall2", lb.stall, 1);
        check("sw_stb2", f_stb, 2'b00);
        step();
        sample();
        check("sw_stb3", f_stb, 2'b10);
        check("sw_stall3", lb.stall, 0);
        for (int k = 0; k < 4; k++) begin
            step();
            drive(1'b1, 1'b0, 1'b0, 32'h1000_0004);
        end
        sample();
        check("sw_pend_end", dut.pending, 0);
        idle(2);

        // Unmapped read: error exactly one cycle after acceptance
        step();
        drive(1'b1, 1'b1, 1'b0, 32'h2000_0000);
        sample();
        check("um_stall0", lb.stall, 0);
        check("um_fcyc0", f_cyc, 0);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h2000_0000);
        sample();
        check("um_err1", lb.error, 1);
        check("um_ack1", lb.ack, 0);
        check("um_rdata1", lb.read_data, 0);
        check("um_fcyc1", f_cyc, 0);
        step();
        sample();
        check("um_err2", lb.error, 0);
        check("um_pend2", dut.pending, 0);
        idle(2);

        // Abort with two outstanding on port 1: late acks are dropped
        lat[1] = 8;
        for (int k = 0; k < 2; k++) begin
            step();
            drive(1'b1, 1'b1, 1'b0, 32'h1000_0000 + 32'(4 * k));
        end
        step();
        drive(1'b0, 1'b0, 1'b0, 32'h1000_0008);
        sample();
        check("ab_fcyc", f_cyc, 0);
        check("ab_pend_before", dut.pending, 2);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h1000_0008);
        sample();
        check("ab_pend_after", dut.pending, 0);
        for (int k = 0; k < 10; k++) begin
            step();
            sample();
            check($sformatf("ab_late_ack%0d", k), lb.ack, 0);
        end
        idle(2);

        // Reset with three outstanding on port 0 while the follower is acking
        lat[0] = 3;
        for (int k = 0; k < 3; k++) begin
            step();
            drive(1'b1, 1'b1, 1'b0, 32'h0000_0100 + 32'(4 * k));
        end
        for (int k = 0; k < 2; k++) begin
            step();
            reset_n = 1'b0;
            drive(1'b0, 1'b0, 1'b0, 32'h1000_0000);
            sample();
            check($sformatf("rst_ack%0d", k), lb.ack, 0);
            check($sformatf("rst_err%0d", k), lb.error, 0);
            check($sformatf("rst_rdata%0d", k), lb.read_data, 0);
            check($sformatf("rst_fcyc%0d", k), f_cyc, 0);
            check($sformatf("rst_pend%0d", k), dut.pending, 0);
        end
        flush_followers();
        lat[1] = 2;
        step();
        reset_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 32'h1000_0000);
        sample();
        check("rst_new_stall", lb.stall, 0);
        check("rst_new_stb", f_stb, 2'b10);
        step();
        drive(1'b1, 1'b0, 1'b0, 32'h1000_0000);
        sample();
        check("rst_new_pend", dut.pending, 1);
        idle(6);

        // Randomized traffic against the transaction-queue model
        err_pct = 20;
        mq.delete();
        for (int k = 0; k < 400; k++) begin
            step();
            sel = $urandom_range(2);
            if (sel == 0) a = $urandom() & 32'h0000_FFFF;
            else if (sel == 1) a = 32'h1000_0000 | ($urandom() & 32'h0FFF_FFFF);
            else a = 32'h8000_0000 | $urandom();
            drive(($urandom_range(19) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)), a);
            for (int p = 0; p < N; p++) begin
                f_stall[p] = ($urandom_range(3) == 0);
                lat[p] = $urandom_range(4, 1);
            end
            sample();
            tgt  = decode(lb.addr);
            busy = (mq.size() > 0);
            head = busy ? mq[0].tgt : N;
            act  = busy ? head : tgt;
            can  = (mq.size() < MaxOut) && (!busy || tgt == head);
            e_stall = !can ? 1'b1 : (act < N) ? f_stall[act] : 1'b0;
            e_ack  = 1'b0;
            e_err  = 1'b0;
            e_data = '0;
            if (busy && head < N) begin
                e_ack  = f_ack[head];
                e_err  = f_err[head];
                e_data = f_rdata[head];
            end else if (busy) begin
                e_err = (cyc == mq[0].acc + 1);
            end
            for (int p = 0; p < N; p++) begin
                e_cyc[p] = lb.cycle && (act == p);
                e_stb[p] = e_cyc[p] && lb.strobe && can;
            end
            check($sformatf("rnd%0d_stall", k), lb.stall, e_stall);
            check($sformatf("rnd%0d_ack", k), lb.ack, e_ack);
            check($sformatf("rnd%0d_err", k), lb.error, e_err);
            check($sformatf("rnd%0d_rdata", k), lb.read_data, e_data);
            check($sformatf("rnd%0d_fcyc", k), f_cyc, e_cyc);
            check($sformatf("rnd%0d_fstb", k), f_stb, e_stb);
            if (!lb.cycle) begin
                mq.delete();
            end else begin
                if (e_ack || e_err) void'(mq.pop_front());
                if (lb.strobe && !e_stall) mq.push_back('{tgt, cyc});
            end
        end
        idle(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
